// File: rtl/video_timing_gen_pkg.sv
// rtl/video_timing_gen_pkg.sv - shared defaults and helpers for the video timing generator
package video_timing_gen_pkg;

`include "video_timing_params.vh"

    localparam int DEF_H_ACTIVE = `VT_640X480_H_ACTIVE;
    localparam int DEF_H_FP     = `VT_640X480_H_FP;
    localparam int DEF_H_SYNC   = `VT_640X480_H_SYNC;
    localparam int DEF_H_BP     = `VT_640X480_H_BP;
    localparam int DEF_V_ACTIVE = `VT_640X480_V_ACTIVE;
    localparam int DEF_V_FP     = `VT_640X480_V_FP;
    localparam int DEF_V_SYNC   = `VT_640X480_V_SYNC;
    localparam int DEF_V_BP     = `VT_640X480_V_BP;
    localparam int DEF_CW       = 12;

    // Maps an "in sync region" flag to the pin level for the chosen polarity.
    function automatic logic sync_level(input logic in_sync, input logic pol);
        return in_sync ? pol : ~pol;
    endfunction

endpackage

// File: rtl/video_axis_cnt.sv
// rtl/video_axis_cnt.sv - one raster axis counter (active, front porch, sync, back porch)
module video_axis_cnt
    import video_timing_gen_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CW     = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          active,
    output logic          sync
);

    localparam int            TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] cnt_q, cnt_d;

    assign wrap = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign active = cnt_q < ACT_END;
    assign sync   = (cnt_q >= SYNC_START) && (cnt_q < SYNC_END);

endmodule

// File: rtl/video_timing_params.vh
// rtl/video_timing_params.vh - raster timing presets (640x480@60 default, 800x480, 480x272)
`ifndef VIDEO_TIMING_PARAMS_VH
`define VIDEO_TIMING_PARAMS_VH

`define VT_640X480_H_ACTIVE 640
`define VT_640X480_H_FP     16
`define VT_640X480_H_SYNC   96
`define VT_640X480_H_BP     48
`define VT_640X480_V_ACTIVE 480
`define VT_640X480_V_FP     10
`define VT_640X480_V_SYNC   2
`define VT_640X480_V_BP     33

`define VT_800X480_H_ACTIVE 800
`define VT_800X480_H_FP     40
`define VT_800X480_H_SYNC   48
`define VT_800X480_H_BP     88
`define VT_800X480_V_ACTIVE 480
`define VT_800X480_V_FP     13
`define VT_800X480_V_SYNC   3
`define VT_800X480_V_BP     32

`define VT_480X272_H_ACTIVE 480
`define VT_480X272_H_FP     2
`define VT_480X272_H_SYNC   41
`define VT_480X272_H_BP     2
`define VT_480X272_V_ACTIVE 272
`define VT_480X272_V_FP     2
`define VT_480X272_V_SYNC   10
`define VT_480X272_V_BP     2

`endif

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing, pixel request and registered RGB565 panel output
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          pix_req,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    input  logic [15:0]   pix_data,
    output logic          lcd_hs,
    output logic          lcd_vs,
    output logic          lcd_de,
    output logic [15:0]   lcd_rgb,
    output logic          frame_start
);

    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_wrap, h_active, h_sync;
    logic          v_wrap_unused, v_active, v_sync;

    video_axis_cnt #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
    ) u_h_cnt (
        .clk(clk), .rst_n(rst_n), .en(1'b1),
        .cnt(h_cnt), .wrap(h_wrap), .active(h_active), .sync(h_sync)
    );

    // The vertical axis only advances on the last pixel of each line.
    video_axis_cnt #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
    ) u_v_cnt (
        .clk(clk), .rst_n(rst_n), .en(h_wrap),
        .cnt(v_cnt), .wrap(v_wrap_unused), .active(v_active), .sync(v_sync)
    );

    logic          pix_req_q, pix_req_d;
    logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic          hs1_q, hs1_d, vs1_q, vs1_d;
    logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic [15:0]   rgb_q, rgb_d;

    always_comb begin
        pix_req_d = h_active && v_active;
        pix_x_d   = pix_req_d ? h_cnt : '0;
        pix_y_d   = pix_req_d ? v_cnt : '0;
        hs1_d     = sync_level(h_sync, SYNC_POL);
        vs1_d     = sync_level(v_sync, SYNC_POL);
    end

    // Stage 2 consumes the returned pixel only for cycles that actually requested one.
    always_comb begin
        de_d  = pix_req_q;
        hs_d  = hs1_q;
        vs_d  = vs1_q;
        rgb_d = pix_req_q ? pix_data : 16'h0000;
        fs_d  = pix_req_q && (pix_x_q == '0) && (pix_y_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_req_q <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            hs1_q     <= ~SYNC_POL;
            vs1_q     <= ~SYNC_POL;
            de_q      <= 1'b0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            rgb_q     <= 16'h0000;
            fs_q      <= 1'b0;
        end else begin
            pix_req_q <= pix_req_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            rgb_q     <= rgb_d;
            fs_q      <= fs_d;
        end
    end

    assign pix_req     = pix_req_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign lcd_de      = de_q;
    assign lcd_hs      = hs_q;
    assign lcd_vs      = vs_q;
    assign lcd_rgb     = rgb_q;
    assign frame_start = fs_q;

endmodule
